// File: rtl/seq_mag_comparator_pkg.sv
// Shared FSM states, one-hot {LT, EQ, GT} result encodings and chunk-count helper
// for the sequential magnitude comparator.
package seq_mag_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

    function automatic int nchunk(input int width, input int chunk);
        if (chunk > 0) begin
            return width / chunk;
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/seq_mag_comparator_chunk.sv
// Purely combinational CHUNK-bit unsigned magnitude compare (one slice of the scan).
module mag_cmp_chunk
    import seq_mag_comparator_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning CHUNK bits per clock, MSB chunk first.
// Optional SEQ_MAG_COMPARATOR_EARLY_EXIT_EN: stop on the first unequal chunk instead of a full scan.
module seq_mag_comparator
    import seq_mag_comparator_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             LT,
    output logic             EQ,
    output logic             GT
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t  IDX_ZERO  = idx_t'(1'b0);
    localparam idx_t  IDX_ONE   = idx_t'(1'b1);
    localparam idx_t  IDX_TOP   = idx_t'(NCHUNK - 1);
    // Flipping the sign bit maps two's complement order onto unsigned order.
    localparam word_t SIGN_FLIP = (SIGNED != 0) ? (word_t'(1'b1) << (WIDTH - 1)) : word_t'(1'b0);

    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $fatal(1, "seq_mag_comparator: CHUNK must be >= 1 and divide WIDTH");
    end

    state_e     state_r, state_nxt_s;
    word_t      a_r, a_nxt_s, b_r, b_nxt_s;
    idx_t       idx_r, idx_nxt_s;
    logic [2:0] res_r, res_nxt_s;
    logic       out_valid_r, out_valid_nxt_s;

    logic [NCHUNK-1:0][CHUNK-1:0] a_chunks_s, b_chunks_s;
    logic       chunk_lt_s, chunk_eq_s, chunk_gt_s;
    logic [2:0] chunk_res_s;

`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
    logic       decided_r, decided_nxt_s;
    logic [2:0] dec_res_r, dec_res_nxt_s;
`endif

    assign a_chunks_s  = a_r;
    assign b_chunks_s  = b_r;
    assign chunk_res_s = {chunk_lt_s, chunk_eq_s, chunk_gt_s};

    mag_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_chunks_s[idx_r]),
        .b  (b_chunks_s[idx_r]),
        .lt (chunk_lt_s),
        .eq (chunk_eq_s),
        .gt (chunk_gt_s)
    );

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign LT        = res_r[2];
    assign EQ        = res_r[1];
    assign GT        = res_r[0];

    // Next-state and datapath update for the IDLE -> CMP -> DONE sequence.
    always_comb begin
        state_nxt_s     = state_r;
        a_nxt_s         = a_r;
        b_nxt_s         = b_r;
        idx_nxt_s       = idx_r;
        res_nxt_s       = res_r;
        out_valid_nxt_s = out_valid_r;
`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
        decided_nxt_s   = decided_r;
        dec_res_nxt_s   = dec_res_r;
`endif
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_nxt_s     = A ^ SIGN_FLIP;
                    b_nxt_s     = B ^ SIGN_FLIP;
                    idx_nxt_s   = IDX_TOP;
                    state_nxt_s = CMP;
`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
                    decided_nxt_s = 1'b0;
                    dec_res_nxt_s = RES_NONE;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMP: begin
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
                if (!chunk_eq_s) begin
                    res_nxt_s       = chunk_res_s;
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = DONE;
                end else if (idx_r == IDX_ZERO) begin
                    res_nxt_s       = RES_EQ;
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = DONE;
                end else begin
                    idx_nxt_s = idx_r - IDX_ONE;
                end
`else
                if (idx_r == IDX_ZERO) begin
                    if (decided_r) begin
                        res_nxt_s = dec_res_r;
                    end else begin
                        res_nxt_s = chunk_res_s;
                    end
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = DONE;
                end else begin
                    idx_nxt_s = idx_r - IDX_ONE;
                    // Only the most significant difference decides the result.
                    if (!decided_r && !chunk_eq_s) begin
                        decided_nxt_s = 1'b1;
                        dec_res_nxt_s = chunk_res_s;
                    end else begin
                        decided_nxt_s = decided_r;
                    end
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, operand, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            idx_r       <= IDX_ZERO;
            res_r       <= RES_NONE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            idx_r       <= idx_nxt_s;
            res_r       <= res_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
    // Sticky first-difference flag and its result for the full-length scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decided_r <= 1'b0;
            dec_res_r <= RES_NONE;
        end else begin
            decided_r <= decided_nxt_s;
            dec_res_r <= dec_res_nxt_s;
        end
    end
`endif

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Multi-cycle N-bit magnitude comparator with valid/ready handshakes on input and output; reports LT/EQ/GT.
- Generalises the team's 1-bit comparator in width, signedness and timing.
- Scans captured operands MSB-chunk-first, one CHUNK-bit slice per clock, so wide compares stay off the critical path.
- Sits between datapath producers and control logic that needs ordered compares.

Parameters:
- WIDTH, 16, operand width in bits; must be ≥ 1.
- CHUNK, 4, bits compared per cycle; must divide WIDTH (elaboration-time check, fatal if violated).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands A/B valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- LT  out  1  A < B.
- EQ  out  1  A == B.
- GT  out  1  A > B.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset state: FSM = IDLE, out_valid = 0, LT = EQ = GT = 0, chunk index = 0. in_ready = 1 as soon as rst_n deasserts.
- Constant: NCHUNK = WIDTH/CHUNK. Chunk i = bits [i*CHUNK+CHUNK-1 : i*CHUNK].
- in_ready is combinational: 1 only in IDLE.
- IDLE:
  - On in_valid & in_ready, register A and B.
  - If SIGNED=1, invert bit WIDTH-1 of both registered operands; the unsigned scan is then correct for two's complement.
  - Set idx = NCHUNK-1, go to CMP.
- CMP (one chunk per cycle):
  - Chunk A > chunk B: GT = 1, others 0, go to DONE.
  - Chunk A < chunk B: LT = 1, others 0, go to DONE.
  - Chunks equal and idx == 0: EQ = 1, go to DONE.
  - Chunks equal and idx > 0: decrement idx, stay in CMP.
  - Exactly one of LT/EQ/GT is set at result write.
- DONE:
  - out_valid = 1; LT/EQ/GT held stable while out_ready = 0.
  - On out_ready = 1: out_valid = 0 next cycle, go to IDLE.
  - LT/EQ/GT keep their last value after the handshake until the next result is written.
- Latency: accept edge to out_valid = k cycles, where k = number of chunks scanned (1..NCHUNK).
- Throughput: at most one operation per k+2 cycles. No accept in the same cycle as the output handshake.
- in_valid while not IDLE: ignored. Operands are not captured and the producer must hold them.
- out_ready while out_valid = 0: no effect.
- Reset mid-operation (CMP or DONE): immediate abort. All outputs return to reset values and the in-flight result is lost.
- WIDTH == CHUNK: a single CMP cycle; behaviour is otherwise identical.

Optional Feature:
- Macro: SEQ_MAG_COMPARATOR_EARLY_EXIT_EN.
- Defined: the CMP exits on the first unequal chunk, as described above; latency is data-dependent, 1..NCHUNK.
- Undefined:
  - The first difference is latched into a sticky decided flag plus a result register.
  - Scanning continues to idx == 0 regardless.
  - Latency is always NCHUNK cycles.
  - LT/EQ/GT values are identical to the defined case.

Decomposition:
- Package seq_mag_comparator_pkg holds:
  - FSM state enum {IDLE, CMP, DONE};
  - a result encoding constant set;
  - function nchunk(WIDTH, CHUNK).
- One sub-module, mag_cmp_chunk: purely combinational CHUNK-bit unsigned compare giving lt/eq/gt. Instantiated once, with its input muxed by idx.

Test Plan (WIDTH=16, CHUNK=4):
- A=0x1234, B=0x1234, SIGNED=0 -> EQ=1, LT=GT=0; out_valid 4 cycles after accept, in both macro settings.
- A=0x8000, B=0x7FFF, SIGNED=0 -> GT=1; out_valid after 1 cycle with SEQ_MAG_COMPARATOR_EARLY_EXIT_EN defined, after 4 cycles without.
- A=0x8000, B=0x7FFF, SIGNED=1 -> LT=1; same latencies as above.
- A=0x0012, B=0x0013, SIGNED=0 -> LT=1 after 4 cycles in both modes.
- Result 0x00FF vs 0x0F00 with out_ready held low 5 cycles; new in_valid with A=B=0 asserted meanwhile:
  - out_valid = 1 and LT = 1 held stable throughout;
  - in_ready = 0 and new operands not captured;
  - after out_ready, next accept yields EQ = 1.
- rst_n pulsed low for 1 cycle during CMP -> out_valid = 0 and LT/EQ/GT = 0 immediately (asynchronous); in_ready = 1 after release; following compare 0xFFFF vs 0x0001 (SIGNED=0) -> GT = 1.
